// File: rtl/seq_pkg.sv
// Shared types and the default program for the command sequencer.
package seq_pkg;

  // Program opcodes; the encoding is part of the program table format.
  typedef enum logic [1:0] {
    OP_DELAY = 2'd0,
    OP_SEND  = 2'd1,
    OP_END   = 2'd2,
    OP_NOP   = 2'd3
  } opcode_t;

  // Sequencer FSM states, also exported on the debug port.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_FETCH    = 3'd1,
    ST_DELAY    = 3'd2,
    ST_SEND     = 3'd3,
    ST_WAIT_ACK = 3'd4,
    ST_DONE     = 3'd5,
    ST_ERROR    = 3'd6
  } seq_state_t;

  // Geometry of the default program table.
  localparam int C_NB_STEPS   = 8;
  localparam int C_DATA_WIDTH = 8;

  // One program entry: opcode in the top two bits, argument below.
  typedef struct packed {
    opcode_t                 opcode;
    logic [C_DATA_WIDTH-1:0] arg;
  } seq_entry_t;

  // Entry 0 sits in the least significant slot.
  typedef seq_entry_t [C_NB_STEPS-1:0] seq_program_t;

  function automatic seq_entry_t mk_entry(input opcode_t op, input logic [C_DATA_WIDTH-1:0] arg);
    seq_entry_t e;
    e.opcode = op;
    e.arg    = arg;
    return e;
  endfunction

  // Default program: wait, send two commands, then stop.
  localparam seq_program_t C_SEQ_PROGRAM = {
    mk_entry(OP_NOP,   8'h00),  // 7
    mk_entry(OP_NOP,   8'h00),  // 6
    mk_entry(OP_NOP,   8'h00),  // 5
    mk_entry(OP_END,   8'h00),  // 4
    mk_entry(OP_SEND,  8'h3C),  // 3
    mk_entry(OP_DELAY, 8'h02),  // 2
    mk_entry(OP_SEND,  8'hA5),  // 1
    mk_entry(OP_DELAY, 8'h03)   // 0
  };

  // Counter width covering both the longest DELAY and the ack timeout.
  function automatic int cnt_width(input int data_width, input int timeout);
    int max_val;
    max_val = (1 << data_width) - 1;
    if (timeout > max_val) max_val = timeout;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sequencer.sv
// Command sequencer: walks a constant program of DELAY/SEND/END/NOP
// entries, issuing command strobes and waiting for acknowledges.
//
// Handshake: cmd_valid is a one-cycle strobe and cmd_data is meaningful
// only while it is high (it reads 0 otherwise). ack is accepted in the
// strobe cycle or in any following WAIT_ACK cycle; ack seen in any other
// state is ignored. No ack within G_TIMEOUT wait cycles ends in ERROR.
module sequencer
  import seq_pkg::*;
#(
  parameter int G_NB_STEPS   = 8,
  parameter int G_DATA_WIDTH = 8,
  parameter int G_TIMEOUT    = 16,
  // Flattened table, entry 0 in the LSBs; must be resized with G_NB_STEPS/G_DATA_WIDTH.
  parameter logic [G_NB_STEPS*(2+G_DATA_WIDTH)-1:0] G_PROGRAM = C_SEQ_PROGRAM
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          start,
  input  logic                          ack,
  output logic                          cmd_valid,
  output logic [G_DATA_WIDTH-1:0]       cmd_data,
  output logic [$clog2(G_NB_STEPS)-1:0] step_idx,
  output logic                          busy,
  output logic                          done,
  output logic                          error,
  output seq_state_t                    dbg_state
);

  localparam int C_EW    = 2 + G_DATA_WIDTH;
  localparam int C_IDX_W = $clog2(G_NB_STEPS);
  localparam int C_CNT_W = cnt_width(G_DATA_WIDTH, G_TIMEOUT);
  localparam logic [C_IDX_W-1:0] C_LAST    = C_IDX_W'(G_NB_STEPS - 1);
  localparam logic [C_CNT_W-1:0] C_TO_LAST = C_CNT_W'(G_TIMEOUT - 1);

  seq_state_t              state, state_nxt;
  logic [C_IDX_W-1:0]      idx_nxt;
  logic [C_CNT_W-1:0]      cnt, cnt_nxt;
  logic                    adv;
  logic [C_EW-1:0]         prog_mem [G_NB_STEPS];
  logic [C_EW-1:0]         cur_entry;
  opcode_t                 cur_op;
  logic [G_DATA_WIDTH-1:0] cur_arg;

  for (genvar g = 0; g < G_NB_STEPS; g++) begin : g_prog
    assign prog_mem[g] = G_PROGRAM[g*C_EW +: C_EW];
  end

  assign cur_entry = prog_mem[step_idx];
  assign cur_op    = opcode_t'(cur_entry[C_EW-1 -: 2]);
  assign cur_arg   = cur_entry[G_DATA_WIDTH-1:0];

  // State, entry index and shared delay/timeout counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= ST_IDLE;
      step_idx <= '0;
      cnt      <= '0;
    end else begin
      state    <= state_nxt;
      step_idx <= idx_nxt;
      cnt      <= cnt_nxt;
    end
  end

  // Next-state logic; "adv" moves to the next entry or finishes after the last.
  always_comb begin
    state_nxt = state;
    idx_nxt   = step_idx;
    cnt_nxt   = cnt;
    adv       = 1'b0;
    case (state)
      ST_IDLE, ST_DONE, ST_ERROR: begin
        if (start) begin
          state_nxt = ST_FETCH;
          idx_nxt   = '0;
          cnt_nxt   = '0;
        end
      end
      ST_FETCH: begin
        case (cur_op)
          OP_DELAY: begin
            if (cur_arg == '0) begin
              adv = 1'b1;
            end else begin
              state_nxt = ST_DELAY;
              cnt_nxt   = '0;
            end
          end
          OP_SEND: state_nxt = ST_SEND;
          OP_END:  state_nxt = ST_DONE;
          default: adv = 1'b1;
        endcase
      end
      ST_DELAY: begin
        if ((cnt + C_CNT_W'(1)) == C_CNT_W'(cur_arg)) adv = 1'b1;
        else                                          cnt_nxt = cnt + C_CNT_W'(1);
      end
      ST_SEND: begin
        if (ack) begin
          adv = 1'b1;
        end else begin
          state_nxt = ST_WAIT_ACK;
          cnt_nxt   = '0;
        end
      end
      ST_WAIT_ACK: begin
        if (ack)                   adv = 1'b1;
        else if (cnt == C_TO_LAST) state_nxt = ST_ERROR;
        else                       cnt_nxt = cnt + C_CNT_W'(1);
      end
      default: state_nxt = ST_IDLE;
    endcase
    if (adv) begin
      cnt_nxt = '0;
      if (step_idx == C_LAST) begin
        state_nxt = ST_DONE;
      end else begin
        state_nxt = ST_FETCH;
        idx_nxt   = step_idx + C_IDX_W'(1);
      end
    end
  end

  // Status and command outputs decoded from the current state.
  always_comb begin
    cmd_valid = (state == ST_SEND);
    cmd_data  = (state == ST_SEND) ? cur_arg : '0;
    done      = (state == ST_DONE);
    error     = (state == ST_ERROR);
    busy      = !(state inside {ST_IDLE, ST_DONE, ST_ERROR});
    dbg_state = state;
  end

endmodule

// File: tb/tb_sequencer.sv
// Bench for the command sequencer: two instances with different programs,
// expected traces derived entry-by-entry from the program rules.
module tb_sequencer;
  import seq_pkg::*;

  localparam int TIMEOUT = 16;
  localparam int OW      = 15;  // {busy, done, error, valid, data[7:0], idx[2:0]}

  // Program A ends with END before the last slot.
  localparam seq_program_t PROG_A = {
    mk_entry(OP_SEND,  8'h5A),  // 7 (unreachable)
    mk_entry(OP_END,   8'h00),  // 6
    mk_entry(OP_DELAY, 8'h01),  // 5
    mk_entry(OP_SEND,  8'h3C),  // 4
    mk_entry(OP_DELAY, 8'h00),  // 3
    mk_entry(OP_NOP,   8'h00),  // 2
    mk_entry(OP_SEND,  8'hA5),  // 1
    mk_entry(OP_DELAY, 8'h03)   // 0
  };

  // Program B has no END and must finish after its last entry.
  localparam seq_program_t PROG_B = {
    mk_entry(OP_NOP,   8'h00),  // 7
    mk_entry(OP_NOP,   8'h00),  // 6
    mk_entry(OP_SEND,  8'h22),  // 5
    mk_entry(OP_NOP,   8'h00),  // 4
    mk_entry(OP_DELAY, 8'h02),  // 3
    mk_entry(OP_NOP,   8'h00),  // 2
    mk_entry(OP_SEND,  8'h11),  // 1
    mk_entry(OP_NOP,   8'h00)   // 0
  };

  // ---------------- clock / reset ----------------
  logic clk;
  logic rst_n;
  logic start_a, start_b, ack;
  logic sel;

  initial clk = 1'b0;
  always #10 clk = ~clk;

  logic       valid_a, busy_a, done_a, err_a;
  logic [7:0] data_a;
  logic [2:0] idx_a;
  seq_state_t st_a;
  logic       valid_b, busy_b, done_b, err_b;
  logic [7:0] data_b;
  logic [2:0] idx_b;
  seq_state_t st_b;

  sequencer #(.G_NB_STEPS(8), .G_DATA_WIDTH(8), .G_TIMEOUT(TIMEOUT), .G_PROGRAM(PROG_A)) u_a (
    .clk(clk), .rst_n(rst_n), .start(start_a), .ack(ack),
    .cmd_valid(valid_a), .cmd_data(data_a), .step_idx(idx_a),
    .busy(busy_a), .done(done_a), .error(err_a), .dbg_state(st_a)
  );

  sequencer #(.G_NB_STEPS(8), .G_DATA_WIDTH(8), .G_TIMEOUT(TIMEOUT), .G_PROGRAM(PROG_B)) u_b (
    .clk(clk), .rst_n(rst_n), .start(start_b), .ack(ack),
    .cmd_valid(valid_b), .cmd_data(data_b), .step_idx(idx_b),
    .busy(busy_b), .done(done_b), .error(err_b), .dbg_state(st_b)
  );

  logic [OW-1:0] obs_a, obs_b, obs;
  assign obs_a = {busy_a, done_a, err_a, valid_a, data_a, idx_a};
  assign obs_b = {busy_b, done_b, err_b, valid_b, data_b, idx_b};
  assign obs   = sel ? obs_b : obs_a;

  // ---------------- scoreboard ----------------
  logic [OW-1:0] exp_q[$];
  logic [1:0]    drv_q[$];   // {start, ack} to drive during each expected cycle
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [OW-1:0] got, input logic [OW-1:0] want);
    n_checks++;
    assert (got === want) else begin
      n_errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, want);
    end
  endtask

  function automatic logic [OW-1:0] mk_obs(input logic b, input logic d, input logic e,
                                           input logic v, input logic [7:0] data, input int idx);
    logic [2:0] i3;
    i3 = idx[2:0];
    return {b, d, e, v, data, i3};
  endfunction

  function automatic logic noise(input int ack_mode);
    return (ack_mode == 0) ? ($urandom_range(0, 1) == 1) : 1'b0;
  endfunction

  // ---------------- reference model ----------------
  // ack_mode: 0 random ack latency (may never come), 1 ack tied low, 2 ack two cycles after strobe.
  task automatic build_trace(input bit use_b, input int ack_mode);
    seq_program_t prog;
    opcode_t      op;
    logic [7:0]   arg;
    int           idx, lat;
    bit           fin, failed;
    logic         st;
    prog   = use_b ? PROG_B : PROG_A;
    idx    = 0;
    fin    = 1'b0;
    failed = 1'b0;
    exp_q.delete();
    drv_q.delete();
    while (!fin) begin
      op  = prog[idx].opcode;
      arg = prog[idx].arg;
      // fetch cycle; a start here must be ignored
      st = ($urandom_range(0, 3) == 0);
      exp_q.push_back(mk_obs(1, 0, 0, 0, 8'h00, idx));
      drv_q.push_back({st, noise(ack_mode)});
      case (op)
        OP_DELAY: begin
          for (int k = 0; k < int'(arg); k++) begin
            st = ($urandom_range(0, 3) == 0);
            exp_q.push_back(mk_obs(1, 0, 0, 0, 8'h00, idx));
            drv_q.push_back({st, noise(ack_mode)});
          end
        end
        OP_SEND: begin
          if (ack_mode == 0)      lat = $urandom_range(0, TIMEOUT + 2);
          else if (ack_mode == 1) lat = TIMEOUT + 1;
          else                    lat = 2;
          // strobe cycle plus up to TIMEOUT waiting cycles
          for (int j = 0; j <= TIMEOUT && j <= lat; j++) begin
            st = ($urandom_range(0, 3) == 0);
            exp_q.push_back(mk_obs(1, 0, 0, (j == 0), (j == 0) ? arg : 8'h00, idx));
            drv_q.push_back({st, (j == lat)});
          end
          if (lat > TIMEOUT) failed = 1'b1;
        end
        default: ;
      endcase
      if (op == OP_END || failed || idx == 7) fin = 1'b1;
      else                                    idx++;
    end
    // final status holds with no start
    for (int k = 0; k < 4; k++) begin
      exp_q.push_back(mk_obs(0, !failed, failed, 0, 8'h00, idx));
      drv_q.push_back({1'b0, noise(ack_mode)});
    end
  endtask

  // ---------------- driver ----------------
  task automatic run_trace(input bit use_b, input string tag);
    logic [OW-1:0] e;
    logic [1:0]    d;
    int            cyc;
    sel = use_b;
    if (use_b) start_b = 1'b1; else start_a = 1'b1;
    ack = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      d = drv_q.pop_front();
      check($sformatf("%s.cyc%0d", tag, cyc), obs, e);
      if (use_b) start_b = d[1]; else start_a = d[1];
      ack = d[0];
      cyc++;
      @(negedge clk);
    end
    start_a = 1'b0;
    start_b = 1'b0;
    ack     = 1'b0;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n   = 1'b0;
    start_a = 1'b0;
    start_b = 1'b0;
    ack     = 1'b0;
    sel     = 1'b0;

    // reset held 3 cycles: all outputs low, FSM idle
    repeat (3) @(negedge clk);
    check("rst_a_outs", obs_a, '0);
    check("rst_b_outs", obs_b, '0);
    check("rst_a_state", OW'(st_a), OW'(ST_IDLE));
    check("rst_b_state", OW'(st_b), OW'(ST_IDLE));
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check($sformatf("rel_idle_a%0d", k), obs_a, '0);
      check($sformatf("rel_idle_b%0d", k), obs_b, '0);
    end

    // reset during DELAY aborts at once, then the block waits in IDLE
    start_a = 1'b1;
    @(negedge clk);
    check("abort_fetch", obs_a, mk_obs(1, 0, 0, 0, 8'h00, 0));
    start_a = 1'b1;  // ignored while busy
    @(negedge clk);
    start_a = 1'b0;
    check("abort_delay", obs_a, mk_obs(1, 0, 0, 0, 8'h00, 0));
    check("abort_delay_st", OW'(st_a), OW'(ST_DELAY));
    #2 rst_n = 1'b0;
    #1;
    check("abort_async_outs", obs_a, '0);
    check("abort_async_st", OW'(st_a), OW'(ST_IDLE));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      check($sformatf("abort_idle%0d", k), obs_a, '0);
    end

    // full program A with ack two cycles after the strobe: ends in DONE at entry 6
    build_trace(1'b0, 2);
    run_trace(1'b0, "a_ack2");

    // program A with ack tied low: times out on the first SEND
    build_trace(1'b0, 1);
    run_trace(1'b0, "a_timeout");

    // program B, no END: finishes after entry 7 without wrapping
    build_trace(1'b1, 2);
    run_trace(1'b1, "b_noend");

    // randomized ack timing on both programs, restarting from DONE/ERROR
    for (int r = 0; r < 10; r++) begin
      build_trace(r[0], 0);
      run_trace(r[0], $sformatf("rand%0d", r));
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
